// File: rtl/fetch_if.sv
// Fetch-stage bus: downstream stall/redirect, instruction-memory port and decode-facing head.
interface fetch_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_rsp_valid_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              valid_o;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rsp_valid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, valid_o, pc_o, insn_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rsp_valid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, valid_o, pc_o, insn_o
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one word read per cycle to a 1-cycle imem and
// buffers {pc,insn} responses in a 2-entry FIFO whose head feeds decode.
module fetch_unit #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000),
    parameter logic [DWIDTH-1:0] INSN_NOP = DWIDTH'(32'h0000_0013)
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int unsigned       DEPTH      = 2;
    localparam logic [AWIDTH-1:0] PC_STEP    = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ALIGN_MASK = ~AWIDTH'(3);

    logic [AWIDTH-1:0] r_pc_q;
    logic              r_inflight;
    logic [AWIDTH-1:0] r_inflight_pc;
    logic [AWIDTH-1:0] r_fifo_pc   [DEPTH];
    logic [DWIDTH-1:0] r_fifo_insn [DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [AWIDTH-1:0] w_redir_addr;

    // Occupancy counts the in-flight word so a response can never overflow the FIFO.
    always_comb begin
        w_redir_addr = bus.redirect_pc_i & ALIGN_MASK;
        w_valid      = (r_count != 2'd0);
        w_pop        = w_valid & ~bus.stall_i & ~bus.redirect_i;
        w_push       = bus.imem_rsp_valid_i & r_inflight & ~bus.redirect_i;
        w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        w_issue      = bus.redirect_i | (w_occ < 3'd2);
    end

    assign bus.imem_req_o  = w_issue & ~rst;
    assign bus.imem_addr_o = bus.redirect_i ? w_redir_addr : r_pc_q;
    assign bus.valid_o     = w_valid;
    assign bus.pc_o        = w_valid ? r_fifo_pc[r_rd_ptr]   : r_pc_q;
    assign bus.insn_o      = w_valid ? r_fifo_insn[r_rd_ptr] : INSN_NOP;

    // FIFO payload storage; contents are qualified by r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
            r_fifo_insn[r_wr_ptr] <= bus.imem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q        <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else if (bus.redirect_i) begin
            // Flush and restart; the response arriving this cycle is discarded.
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redir_addr;
            r_pc_q        <= w_redir_addr + PC_STEP;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_pc_q;
                r_pc_q        <= r_pc_q + PC_STEP;
            end else begin
                r_inflight    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XK     = 32'h5A5A_5A5A;   // memory word = addr ^ XK

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    fetch_unit #(.DWIDTH(DW), .AWIDTH(AW), .RESET_PC(RST_PC), .INSN_NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_pc   [$];
    logic [31:0] q_insn [$];
    bit          m_infl    = 1'b0;
    logic [31:0] m_infl_pc = RST_PC;
    logic [31:0] m_pc      = RST_PC;
    bit          mem_pend  = 1'b0;
    logic [31:0] mem_addr  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the FIFO is a queue of fetched words, plus the one word in flight.
    always @(negedge clk) begin
        bit          e_valid, pop, issue, e_req;
        logic [31:0] e_pc, e_insn, e_addr, tgt;
        int          occ;
        e_valid = (q_pc.size() != 0);
        e_pc    = e_valid ? q_pc[0]   : m_pc;
        e_insn  = e_valid ? q_insn[0] : NOP;
        tgt     = bus.redirect_pc_i & ~32'd3;
        pop     = e_valid && !bus.stall_i && !bus.redirect_i;
        occ     = q_pc.size() + int'(m_infl) - int'(pop);
        issue   = bus.redirect_i || (occ < 2);
        e_req   = !rst && issue;
        e_addr  = bus.redirect_i ? tgt : m_pc;

        check("model_valid", 32'(bus.valid_o), 32'(e_valid));
        check("model_pc", bus.pc_o, e_pc);
        check("model_insn", bus.insn_o, e_insn);
        check("model_req", 32'(bus.imem_req_o), 32'(e_req));
        if (e_req) check("model_addr", bus.imem_addr_o, e_addr);

        mem_pend = bus.imem_req_o;
        mem_addr = bus.imem_addr_o;

        if (rst) begin
            q_pc.delete(); q_insn.delete();
            m_infl = 1'b0; m_pc = RST_PC;
        end else if (bus.redirect_i) begin
            q_pc.delete(); q_insn.delete();
            m_infl = 1'b1; m_infl_pc = tgt; m_pc = tgt + 32'd4;
        end else begin
            if (pop) begin
                void'(q_pc.pop_front()); void'(q_insn.pop_front());
            end
            if (bus.imem_rsp_valid_i && m_infl) begin
                q_pc.push_back(m_infl_pc); q_insn.push_back(bus.imem_rdata_i);
            end
            if (issue) begin
                m_infl = 1'b1; m_infl_pc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    end

    // Advance one cycle; the memory answers last cycle's request.
    task automatic step();
        @(posedge clk);
        #1;
        bus.imem_rsp_valid_i = mem_pend;
        bus.imem_rdata_i     = mem_pend ? (mem_addr ^ XK) : 32'hDEAD_BEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.imem_rsp_valid_i = 1'b0; bus.imem_rdata_i = 32'h0;
        repeat (2) step();

        // Reset release: steady stream from RESET_PC
        rst = 1'b0;
        @(negedge clk);
        check("c0_req", 32'(bus.imem_req_o), 32'd1);
        check("c0_addr", bus.imem_addr_o, 32'h0100_0000);
        check("c0_valid", 32'(bus.valid_o), 32'd0);
        check("c0_insn_nop", bus.insn_o, NOP);
        step(); @(negedge clk);
        check("c1_valid", 32'(bus.valid_o), 32'd0);
        check("c1_addr", bus.imem_addr_o, 32'h0100_0004);
        step(); @(negedge clk);
        check("c2_valid", 32'(bus.valid_o), 32'd1);
        check("c2_pc", bus.pc_o, 32'h0100_0000);
        check("c2_insn", bus.insn_o, 32'h5B5A_5A5A);
        step(); @(negedge clk);
        check("c3_pc", bus.pc_o, 32'h0100_0004);
        check("c3_insn", bus.insn_o, 32'h5B5A_5A5E);
        repeat (3) step();

        // Stall for 5 cycles (c6..c10), with a spurious response while nothing is in flight
        bus.stall_i = 1'b1;
        @(negedge clk);
        check("stall_req_drop", 32'(bus.imem_req_o), 32'd0);
        check("stall_pc", bus.pc_o, 32'h0100_0010);
        repeat (2) step();
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stall_req_off", 32'(bus.imem_req_o), 32'd0);
        check("stall_pc_frozen", bus.pc_o, 32'h0100_0010);
        check("stall_insn_frozen", bus.insn_o, 32'h5B5A_5A4A);
        repeat (3) step();
        bus.stall_i = 1'b0;
        @(negedge clk);
        check("rel_pc0", bus.pc_o, 32'h0100_0010);
        step(); @(negedge clk);
        check("rel_pc1", bus.pc_o, 32'h0100_0014);
        step(); @(negedge clk);
        check("rel_pc2", bus.pc_o, 32'h0100_0018);
        check("rel_insn2", bus.insn_o, 32'h5B5A_5A42);

        // Redirect to a misaligned target
        step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0100_0043;
        @(negedge clk);
        check("redir_req", 32'(bus.imem_req_o), 32'd1);
        check("redir_addr", bus.imem_addr_o, 32'h0100_0040);
        step();
        bus.redirect_i = 1'b0;
        @(negedge clk);
        check("redir_t1_valid", 32'(bus.valid_o), 32'd0);
        step(); @(negedge clk);
        check("redir_t2_valid", 32'(bus.valid_o), 32'd1);
        check("redir_t2_pc", bus.pc_o, 32'h0100_0040);
        step(); @(negedge clk);
        check("redir_t3_pc", bus.pc_o, 32'h0100_0044);

        // Redirect while stalled with the FIFO full
        step();
        bus.stall_i = 1'b1;
        repeat (4) step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0100_0200;
        @(negedge clk);
        check("rs_addr", bus.imem_addr_o, 32'h0100_0200);
        check("rs_req", 32'(bus.imem_req_o), 32'd1);
        step();
        bus.redirect_i = 1'b0;
        @(negedge clk);
        check("rs_t1_valid", 32'(bus.valid_o), 32'd0);
        step(); @(negedge clk);
        check("rs_t2_pc", bus.pc_o, 32'h0100_0200);
        step(); @(negedge clk);
        check("rs_t3_pc_held", bus.pc_o, 32'h0100_0200);
        bus.stall_i = 1'b0;
        repeat (3) step();

        // Reset mid-stream with stall held
        bus.stall_i = 1'b1;
        step();
        rst = 1'b1;
        step(); @(negedge clk);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_insn", bus.insn_o, NOP);
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_pc", bus.pc_o, RST_PC);
        step();
        rst = 1'b0; bus.stall_i = 1'b0;
        @(negedge clk);
        check("restart_addr", bus.imem_addr_o, RST_PC);
        repeat (2) step(); @(negedge clk);
        check("restart_pc", bus.pc_o, RST_PC);

        // PC wrap at the top of the address space
        step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFE;
        @(negedge clk);
        check("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
        step();
        bus.redirect_i = 1'b0;
        @(negedge clk);
        check("wrap_addr1", bus.imem_addr_o, 32'h0000_0000);
        step(); @(negedge clk);
        check("wrap_pc0", bus.pc_o, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        check("wrap_pc1", bus.pc_o, 32'h0000_0000);
        check("wrap_insn1", bus.insn_o, XK);
        repeat (4) step();

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
